// File: rtl/relogio_pkg.sv
// Shared time-field definitions and field limits for the clock counter and
// the adjustment logic.
package relogio_pkg;

  typedef logic [5:0] tfield_t;

  localparam tfield_t MAX_HORA = 6'd23;
  localparam tfield_t MAX_MIN  = 6'd59;
  localparam tfield_t MAX_SEG  = 6'd59;

  function automatic tfield_t clamp_field(input tfield_t value, input tfield_t limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/relogio_contador_bin2bcd.sv
// Combinational split of a 0..63 binary field into tens and units BCD digits.
module bin2bcd
  import relogio_pkg::*;
(
  input  tfield_t    bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  always_comb begin
    tens  = 4'(bin / 6'd10);
    units = 4'(bin % 6'd10);
  end

endmodule

// File: rtl/relogio_contador.sv
// Time-of-day counter: prescaled one-second tick, HH:MM:SS rollover, clamped
// load from the adjustment block, and BCD digit outputs.
module relogio_contador
  import relogio_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       modo_ajuste,
  input  logic       adjust,
  input  tfield_t    horas_in,
  input  tfield_t    minutos_in,
  input  tfield_t    segundos_in,
  output tfield_t    horas,
  output tfield_t    minutos,
  output tfield_t    segundos,
  output logic [3:0] hou_tens,
  output logic [3:0] hou_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       tick,
  output logic       dia_wrap
);

  localparam int            PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  tfield_t       horas_q, horas_d;
  tfield_t       minutos_q, minutos_d;
  tfield_t       segundos_q, segundos_d;
  logic          tick_q, tick_d;
  logic          dia_wrap_q, dia_wrap_d;
  logic          inc;

  // A load always wins over a coincident increment and suppresses its pulses.
  always_comb begin
    inc        = !modo_ajuste && (presc_q == PRESC_MAX);
    presc_d    = presc_q;
    horas_d    = horas_q;
    minutos_d  = minutos_q;
    segundos_d = segundos_q;
    tick_d     = 1'b0;
    dia_wrap_d = 1'b0;

    if (adjust) begin
      presc_d    = '0;
      horas_d    = clamp_field(horas_in, MAX_HORA);
      minutos_d  = clamp_field(minutos_in, MAX_MIN);
      segundos_d = clamp_field(segundos_in, MAX_SEG);
    end else if (!modo_ajuste) begin
      presc_d = inc ? '0 : presc_q + 1'b1;
      if (inc) begin
        tick_d = 1'b1;
        if (segundos_q == MAX_SEG) begin
          segundos_d = '0;
          if (minutos_q == MAX_MIN) begin
            minutos_d = '0;
            if (horas_q == MAX_HORA) begin
              horas_d    = '0;
              dia_wrap_d = 1'b1;
            end else begin
              horas_d = horas_q + 6'd1;
            end
          end else begin
            minutos_d = minutos_q + 6'd1;
          end
        end else begin
          segundos_d = segundos_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      horas_q    <= '0;
      minutos_q  <= '0;
      segundos_q <= '0;
      tick_q     <= 1'b0;
      dia_wrap_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      horas_q    <= horas_d;
      minutos_q  <= minutos_d;
      segundos_q <= segundos_d;
      tick_q     <= tick_d;
      dia_wrap_q <= dia_wrap_d;
    end
  end

  assign horas    = horas_q;
  assign minutos  = minutos_q;
  assign segundos = segundos_q;
  assign tick     = tick_q;
  assign dia_wrap = dia_wrap_q;

  bin2bcd u_bcd_horas    (.bin(horas_q),    .tens(hou_tens), .units(hou_units));
  bin2bcd u_bcd_minutos  (.bin(minutos_q),  .tens(min_tens), .units(min_units));
  bin2bcd u_bcd_segundos (.bin(segundos_q), .tens(sec_tens), .units(sec_units));

endmodule

// File: tb/tb_relogio_contador.sv
// Scoreboard bench for relogio_contador with a 4-cycle second.
module tb_relogio_contador;

  typedef struct packed {
    logic [5:0] h, m, s;
    logic [3:0] ht, hu, mt, mu, st, su;
    logic       tk, wr;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       modo_ajuste = 1'b0;
  logic       adjust = 1'b0;
  logic [5:0] horas_in = '0, minutos_in = '0, segundos_in = '0;
  logic [5:0] horas, minutos, segundos;
  logic [3:0] hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units;
  logic       tick, dia_wrap;

  int   checks = 0;
  int   failures = 0;
  out_t sb[$];
  out_t e, o;

  always #5 clk = ~clk;

  relogio_contador #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .modo_ajuste(modo_ajuste), .adjust(adjust),
    .horas_in(horas_in), .minutos_in(minutos_in), .segundos_in(segundos_in),
    .horas(horas), .minutos(minutos), .segundos(segundos),
    .hou_tens(hou_tens), .hou_units(hou_units), .min_tens(min_tens),
    .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
    .tick(tick), .dia_wrap(dia_wrap)
  );

  function automatic out_t exp_of(int h, int m, int s, bit tk, bit wr);
    out_t r;
    r.h = 6'(h); r.m = 6'(m); r.s = 6'(s);
    r.ht = 4'(h / 10); r.hu = 4'(h % 10);
    r.mt = 4'(m / 10); r.mu = 4'(m % 10);
    r.st = 4'(s / 10); r.su = 4'(s % 10);
    r.tk = tk; r.wr = wr;
    return r;
  endfunction

  function automatic out_t observe();
    return {horas, minutos, segundos, hou_tens, hou_units, min_tens, min_units,
            sec_tens, sec_units, tick, dia_wrap};
  endfunction

  // One-cycle adjust strobe, driven on a falling edge.
  task automatic load(input int h, input int m, input int s);
    horas_in = 6'(h); minutos_in = 6'(m); segundos_in = 6'(s);
    adjust = 1'b1;
    @(negedge clk);
    adjust = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    sb.push_back(exp_of(0, 0, 0, 0, 0));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", o, e); end
  endtask

  task automatic test_count();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(exp_of(0, 0, 0, 0, 0));
    sb.push_back(exp_of(0, 0, 1, 1, 0));
    sb.push_back(exp_of(0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL count_c%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_day_wrap();
    load(23, 59, 59);
    sb.push_back(exp_of(23, 59, 59, 0, 0));
    for (int i = 0; i < 3; i++) sb.push_back(exp_of(23, 59, 59, 0, 0));
    sb.push_back(exp_of(0, 0, 0, 1, 1));
    sb.push_back(exp_of(0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL day_wrap_c%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_clamp();
    modo_ajuste = 1'b1;
    load(30, 61, 45);
    sb.push_back(exp_of(23, 59, 45, 0, 0));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL clamp_30_61_45 got=%h exp=%h", o, e); end
    load(24, 60, 60);
    sb.push_back(exp_of(23, 59, 59, 0, 0));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL clamp_24_60_60 got=%h exp=%h", o, e); end
    load(63, 63, 0);
    sb.push_back(exp_of(23, 59, 0, 0, 0));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL clamp_63_63_0 got=%h exp=%h", o, e); end
    modo_ajuste = 1'b0;
  endtask

  task automatic test_freeze();
    load(12, 34, 9);
    repeat (3) @(negedge clk);
    @(negedge clk);
    sb.push_back(exp_of(12, 34, 10, 1, 0));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL freeze_pre got=%h exp=%h", o, e); end
    modo_ajuste = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sb.push_back(exp_of(12, 34, 10, 0, 0));
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL freeze_c%0d got=%h exp=%h", i, o, e); end
    end
    modo_ajuste = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back(exp_of(12, 34, 10, 0, 0));
    sb.push_back(exp_of(12, 34, 11, 1, 0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL resume_c%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    load(5, 5, 5);
    repeat (3) @(negedge clk);
    load(1, 2, 3);
    sb.push_back(exp_of(1, 2, 3, 0, 0));
    for (int i = 0; i < 3; i++) sb.push_back(exp_of(1, 2, 3, 0, 0));
    sb.push_back(exp_of(1, 2, 4, 1, 0));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL adjust_on_wrap_c%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_async_reset();
    load(10, 10, 10);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    sb.push_back(exp_of(0, 0, 0, 0, 0));
    e = sb.pop_front(); o = observe(); checks++;
    if (o !== e) begin failures++; $display("FAIL async_reset got=%h exp=%h", o, e); end
    @(negedge clk);
    horas_in = 6'd7; minutos_in = 6'd7; segundos_in = 6'd7;
    adjust = 1'b1;
    @(negedge clk);
    adjust = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(exp_of(0, 0, 0, 0, 0));
    sb.push_back(exp_of(0, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb.pop_front(); o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL post_reset_c%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_day_wrap();
    test_clamp();
    test_freeze();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
